// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic logic [3:0] onehot_to_bin(input logic [15:0] oh);
      logic [3:0] b;
      b = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) b = b | 4'(i);
      end
      return b;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set, unmasked req bit
// found from start upward, wrapping at N.
module rr_pick #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] start,
   input  logic [N-1:0]   excl,
   output logic           found,
   output logic [IDW-1:0] idx
);

   logic [N-1:0] cand;

   assign cand = req & ~excl;

   // Walk offsets high to low so the nearest candidate wins last.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = (int'(start) + i) % N;
         if (cand[j]) begin
            found = 1'b1;
            idx   = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant, ownership held
// while requested, forced rotation after MAX_HOLD cycles.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic           any_req,
   output logic           preempt
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

   arb_state_t     state, state_n;
   logic [IDW-1:0] last, last_n, start;
   logic [HW-1:0]  hold_cnt, hold_n;
   logic [N-1:0]   gnt_n, excl;
   logic           pre_n, own_req, found;
   logic [IDW-1:0] idx;

   assign any_req   = |req;
   assign gnt_valid = |gnt;
   assign gnt_id    = IDW'(onehot_to_bin(16'(gnt)));

   assign own_req = req[last];
   assign start   = (last == IDW'(N - 1)) ? '0 : last + 1'b1;
   assign excl    = (state == GRANT) ? (ONE << last) : '0;

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req   (req),
      .start (start),
      .excl  (excl),
      .found (found),
      .idx   (idx)
   );

   always_comb begin
      state_n = state;
      last_n  = last;
      hold_n  = hold_cnt;
      gnt_n   = gnt;
      pre_n   = 1'b0;
      unique case (state)
         IDLE: begin
            gnt_n = '0;
            if (found) begin
               gnt_n   = ONE << idx;
               last_n  = idx;
               hold_n  = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (own_req && hold_cnt != HOLD_LAST) begin
               hold_n = hold_cnt + 1'b1;
            end else if (own_req) begin
               // Timeout: rotate if anyone else waits, else re-grant.
               hold_n = '0;
               if (found) begin
                  gnt_n  = ONE << idx;
                  last_n = idx;
                  pre_n  = 1'b1;
               end
            end else begin
               hold_n = '0;
               if (found) begin
                  gnt_n  = ONE << idx;
                  last_n = idx;
               end else begin
                  gnt_n   = '0;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= IDW'(N - 1);
         hold_cnt <= '0;
         gnt      <= '0;
         preempt  <= 1'b0;
      end else begin
         state    <= state_n;
         last     <= last_n;
         hold_cnt <= hold_n;
         gnt      <= gnt_n;
         preempt  <= pre_n;
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: default instance plus a
// MAX_HOLD=1 instance for per-cycle rotation.
module tb_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_a = '0;
   logic [3:0] req_b = '0;

   logic [3:0] gnt_a, gnt_b;
   logic       val_a, val_b;
   logic [1:0] id_a, id_b;
   logic       any_a, any_b;
   logic       pre_a, pre_b;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   rr_arbiter #(.N(4), .MAX_HOLD(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_a),
      .gnt       (gnt_a),
      .gnt_valid (val_a),
      .gnt_id    (id_a),
      .any_req   (any_a),
      .preempt   (pre_a)
   );

   rr_arbiter #(.N(4), .MAX_HOLD(1)) u_rr1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_b),
      .gnt       (gnt_b),
      .gnt_valid (val_b),
      .gnt_id    (id_b),
      .any_req   (any_b),
      .preempt   (pre_b)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       val;
      logic       pre;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                               input logic [1:0] i, input logic v,
                               input logic p);
      vec_t t;
      t.req = r; t.gnt = g; t.id = i; t.val = v; t.pre = p;
      return t;
   endfunction

   task automatic step_a(input logic [3:0] r);
      @(negedge clk);
      req_a = r;
      #1;
      check("any_req", 32'(any_a), 32'(r != 4'b0));
      @(posedge clk);
      #1;
   endtask

   logic [3:0] seq_g[6];
   logic       seq_p[6];

   initial begin
      // owner 0 holds 8 cycles, then preempted by 2
      vecs.push_back(mk(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0));
      for (int i = 0; i < 7; i++)
         vecs.push_back(mk(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0));
      vecs.push_back(mk(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b1));
      vecs.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
      // owner 2 drops as 3 and 0 rise: direct handoff to 3
      vecs.push_back(mk(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0));
      vecs.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
      vecs.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
      // single short request, then idle
      vecs.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
      vecs.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
      vecs.push_back(mk(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
      vecs.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
      // last=1: search starts at 2 and wraps to 0
      vecs.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0));
      vecs.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));

      seq_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      seq_p = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      // reset state
      #12;
      check("rst_gnt", 32'(gnt_a), 32'h0);
      check("rst_val", 32'(val_a), 32'h0);
      check("rst_id", 32'(id_a), 32'h0);
      check("rst_pre", 32'(pre_a), 32'h0);
      check("rst_gnt_b", 32'(gnt_b), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // MAX_HOLD=1: per-cycle rotation
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         req_b = 4'b1111;
         @(posedge clk);
         #1;
         check($sformatf("rr1_gnt[%0d]", i), 32'(gnt_b), 32'(seq_g[i]));
         check($sformatf("rr1_pre[%0d]", i), 32'(pre_b), 32'(seq_p[i]));
      end
      @(negedge clk);
      req_b = 4'b0000;

      foreach (vecs[k]) begin
         step_a(vecs[k].req);
         check($sformatf("v%0d_gnt", k), 32'(gnt_a), 32'(vecs[k].gnt));
         check($sformatf("v%0d_id", k), 32'(id_a), 32'(vecs[k].id));
         check($sformatf("v%0d_val", k), 32'(val_a), 32'(vecs[k].val));
         check($sformatf("v%0d_pre", k), 32'(pre_a), 32'(vecs[k].pre));
      end

      // single requester held 20 cycles: no preemption
      for (int i = 0; i < 20; i++) begin
         step_a(4'b1000);
         check($sformatf("solo_gnt[%0d]", i), 32'(gnt_a), 32'h8);
         check($sformatf("solo_pre[%0d]", i), 32'(pre_a), 32'h0);
      end

      // handoff to 2, then async reset mid-grant
      step_a(4'b0100);
      check("pre_rst_gnt", 32'(gnt_a), 32'h4);
      check("pre_rst_id", 32'(id_a), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_gnt", 32'(gnt_a), 32'h0);
      check("async_id", 32'(id_a), 32'h0);
      check("async_val", 32'(val_a), 32'h0);
      req_a = 4'b0000;
      #1;
      check("rst_any0", 32'(any_a), 32'h0);
      req_a = 4'b1111;
      #1;
      check("rst_any1", 32'(any_a), 32'h1);
      @(posedge clk);
      #1;
      check("held_rst_gnt", 32'(gnt_a), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_gnt", 32'(gnt_a), 32'h1);
      check("post_rst_id", 32'(id_a), 32'h0);
      check("post_rst_pre", 32'(pre_a), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
